cp0_exception_ctrl: RTL and testbench

//  Sequences precise exceptions, interrupts and ERET against CP0 from the MEM stage.

---
 rtl/cp0_exception_ctrl_pkg.sv | 45 ++++
 rtl/cp0_int_sync.sv | 26 ++
 rtl/cp0_exception_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared definitions for the CP0 exception sequencer.
//   - ExcCode values written into Cause.ExcCode
//   - Status / Cause bit positions used for interrupt qualification
//   - bit positions inside the MEM-stage exception flag vector
//   - FSM state type and the default exception entry vector
package cp0_exception_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status / Cause bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int CA_IP_LO = 8;

  // Bit positions in mem_exc_i = {eret,ades,adel_d,ov,ri,adel_f,brk}
  localparam int EB_BRK    = 0;
  localparam int EB_ADEL_F = 1;
  localparam int EB_RI     = 2;
  localparam int EB_OV     = 3;
  localparam int EB_ADEL_D = 4;
  localparam int EB_ADES   = 5;
  localparam int EB_ERET   = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_HOLD  = 2'd2
  } exc_state_e;

  // EPC for a delay-slot instruction points at the branch; wraps modulo 2^32.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
    return in_ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchroniser for the hardware interrupt lines.
//   clk, rst  : clock, synchronous active-high reset
//   async_in  : asynchronous interrupt lines
//   sync_out  : synchronised lines, two cycles behind async_in
module cp0_int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0  <= '0;
      sync_out <= '0;
    end else begin
      meta_p0  <= async_in;
      sync_out <= meta_p0;
    end
  end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Precise exception / interrupt / ERET sequencer at the MEM stage.
// Priority-encodes the MEM-stage exception flags together with the
// synchronised hardware interrupts, then issues a one-cycle CP0 update
// strobe plus a pipeline flush and redirect PC. Status/Cause/EPC inputs
// come from the CP0 bypass path so in-flight MTC0 writes are honoured.
//   Inputs : clk, rst, mem_valid_i, mem_exc_i, mem_sys_i, mem_pc_i,
//            mem_in_ds_i, mem_bad_vaddr_i, hw_int_i, cp0_status_i,
//            cp0_cause_i, cp_epc_i
//   Outputs: flush_o, redirect_pc_o, exc_we_o, exc_code_o, exc_epc_o,
//            exc_bd_o, exc_epc_we_o, badvaddr_we_o, exc_badvaddr_o,
//            eret_o, int_pending_o (all registered)
module cp0_exception_ctrl
  import cp0_exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [6:0]  mem_exc_i,
  input  logic        mem_sys_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] mem_bad_vaddr_i,
  input  logic [5:0]  hw_int_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp_epc_i,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic        exc_we_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        exc_epc_we_o,
  output logic        badvaddr_we_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        eret_o,
  output logic [5:0]  int_pending_o
);

  exc_state_e  state;
  logic [1:0]  hold_cnt;

  logic        int_req;
  logic [7:0]  ip_vec;
  logic        take;
  logic        is_eret;
  logic [4:0]  code_sel;
  logic        bv_we_sel;
  logic [31:0] bv_sel;
  logic        unused_bits;

  assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                         cp0_cause_i[31:10], cp0_cause_i[7:0]};

  cp0_int_sync #(.WIDTH(6)) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (hw_int_i),
    .sync_out (int_pending_o)
  );

  // Hardware lines feed IP[7:2]; the software bits IP[1:0] come from Cause.
  assign ip_vec  = {int_pending_o, cp0_cause_i[CA_IP_LO+1:CA_IP_LO]};
  assign int_req = mem_valid_i & cp0_status_i[ST_IE] & ~cp0_status_i[ST_EXL] &
                   (|(cp0_status_i[ST_IM_LO+7:ST_IM_LO] & ip_vec));
  assign take    = (state == S_IDLE) & mem_valid_i &
                   (int_req | (|mem_exc_i) | mem_sys_i);

  // Priority encoder: an interrupt beats every synchronous exception so the
  // faulting instruction simply re-executes after the handler returns.
  always_comb begin
    is_eret   = 1'b0;
    code_sel  = EXC_INT;
    bv_we_sel = 1'b0;
    bv_sel    = mem_bad_vaddr_i;
    if (int_req) begin
      code_sel = EXC_INT;
    end else if (mem_exc_i[EB_ADEL_F]) begin
      code_sel  = EXC_ADEL;
      bv_we_sel = 1'b1;
      bv_sel    = mem_pc_i;
    end else if (mem_exc_i[EB_RI]) begin
      code_sel = EXC_RI;
    end else if (mem_exc_i[EB_OV]) begin
      code_sel = EXC_OV;
    end else if (mem_sys_i) begin
      code_sel = EXC_SYS;
    end else if (mem_exc_i[EB_BRK]) begin
      code_sel = EXC_BP;
    end else if (mem_exc_i[EB_ADEL_D]) begin
      code_sel  = EXC_ADEL;
      bv_we_sel = 1'b1;
    end else if (mem_exc_i[EB_ADES]) begin
      code_sel  = EXC_ADES;
      bv_we_sel = 1'b1;
    end else begin
      is_eret = mem_exc_i[EB_ERET];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      hold_cnt       <= 2'd0;
      flush_o        <= 1'b0;
      redirect_pc_o  <= EXC_VECTOR;
      exc_we_o       <= 1'b0;
      exc_code_o     <= 5'd0;
      exc_epc_o      <= 32'd0;
      exc_bd_o       <= 1'b0;
      exc_epc_we_o   <= 1'b0;
      badvaddr_we_o  <= 1'b0;
      exc_badvaddr_o <= 32'd0;
      eret_o         <= 1'b0;
    end else begin
      exc_we_o      <= 1'b0;
      exc_epc_we_o  <= 1'b0;
      badvaddr_we_o <= 1'b0;
      eret_o        <= 1'b0;
      unique case (state)
        // IDLE -> ENTER: capture the winning event
        S_IDLE: begin
          if (take) begin
            state   <= S_ENTER;
            flush_o <= 1'b1;
            if (is_eret) begin
              eret_o        <= 1'b1;
              redirect_pc_o <= cp_epc_i;
            end else begin
              exc_we_o       <= 1'b1;
              exc_code_o     <= code_sel;
              exc_epc_o      <= epc_of(mem_pc_i, mem_in_ds_i);
              exc_bd_o       <= mem_in_ds_i;
              exc_epc_we_o   <= ~cp0_status_i[ST_EXL];
              badvaddr_we_o  <= bv_we_sel;
              exc_badvaddr_o <= bv_sel;
              redirect_pc_o  <= EXC_VECTOR;
            end
          end
        end
        // ENTER -> HOLD/IDLE: strobes drop, flush may be extended
        S_ENTER: begin
          if (FLUSH_CYCLES > 0) begin
            state    <= S_HOLD;
            hold_cnt <= 2'(FLUSH_CYCLES - 1);
          end else begin
            state   <= S_IDLE;
            flush_o <= 1'b0;
          end
        end
        // HOLD -> IDLE: count out the extra flush cycles
        S_HOLD: begin
          if (hold_cnt == 2'd0) begin
            state   <= S_IDLE;
            flush_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 2'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
module tb_cp0_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FC  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 1'b0;
  logic [6:0]  mem_exc_i = '0;
  logic        mem_sys_i = 1'b0;
  logic [31:0] mem_pc_i = '0;
  logic        mem_in_ds_i = 1'b0;
  logic [31:0] mem_bad_vaddr_i = '0;
  logic [5:0]  hw_int_i = '0;
  logic [31:0] cp0_status_i = '0;
  logic [31:0] cp0_cause_i = '0;
  logic [31:0] cp_epc_i = '0;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic        exc_we_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic        exc_bd_o;
  logic        exc_epc_we_o;
  logic        badvaddr_we_o;
  logic [31:0] exc_badvaddr_o;
  logic        eret_o;
  logic [5:0]  int_pending_o;

  int checks = 0;
  int failures = 0;

  cp0_exception_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_exc_i(mem_exc_i),
    .mem_sys_i(mem_sys_i), .mem_pc_i(mem_pc_i), .mem_in_ds_i(mem_in_ds_i),
    .mem_bad_vaddr_i(mem_bad_vaddr_i), .hw_int_i(hw_int_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp_epc_i(cp_epc_i),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .exc_we_o(exc_we_o),
    .exc_code_o(exc_code_o), .exc_epc_o(exc_epc_o), .exc_bd_o(exc_bd_o),
    .exc_epc_we_o(exc_epc_we_o), .badvaddr_we_o(badvaddr_we_o),
    .exc_badvaddr_o(exc_badvaddr_o), .eret_o(eret_o), .int_pending_o(int_pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: flush lasts 1+FC cycles from the edge after an
  // accepted event; events are only accepted once the previous flush ended.
  int          m_busy = 0;
  bit          m_ready = 0;
  logic        m_we, m_eret, m_epcwe, m_bvwe, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bv, m_redirect;
  logic [5:0]  m_pend, m_stage;
  int          prio_code [9] = '{0, 4, 10, 12, 8, 9, 4, 5, 0};

  always @(posedge clk) begin
    logic       int_req;
    logic [8:0] ev;
    int         idx;
    m_we = 0; m_eret = 0; m_epcwe = 0; m_bvwe = 0;
    if (rst) begin
      m_busy = 0; m_redirect = VEC; m_pend = '0; m_stage = '0;
      m_code = '0; m_epc = '0; m_bd = 0; m_bv = '0;
    end else begin
      int_req = mem_valid_i && cp0_status_i[0] && !cp0_status_i[1] &&
                ((cp0_status_i[15:8] & {m_pend, cp0_cause_i[9:8]}) != 8'd0);
      // priority order: int, adel_f, ri, ov, sys, brk, adel_d, ades, eret
      ev = {mem_exc_i[6], mem_exc_i[5], mem_exc_i[4], mem_exc_i[0], mem_sys_i,
            mem_exc_i[3], mem_exc_i[2], mem_exc_i[1], int_req};
      if (m_busy == 0 && mem_valid_i && ev != 9'd0) begin
        idx = 0;
        while (!ev[idx]) idx++;
        m_busy = 1 + FC;
        if (idx == 8) begin
          m_eret = 1; m_redirect = cp_epc_i;
        end else begin
          m_we = 1;
          m_code = 5'(prio_code[idx]);
          m_epc = mem_in_ds_i ? mem_pc_i - 32'd4 : mem_pc_i;
          m_bd = mem_in_ds_i;
          m_epcwe = !cp0_status_i[1];
          m_bvwe = (idx == 1) || (idx == 6) || (idx == 7);
          m_bv = (idx == 1) ? mem_pc_i : mem_bad_vaddr_i;
          m_redirect = VEC;
        end
      end else if (m_busy > 0) begin
        m_busy--;
      end
      m_pend = m_stage;
      m_stage = hw_int_i;
    end
    m_ready = 1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("flush", flush_o, m_busy > 0);
      chk("exc_we", exc_we_o, m_we);
      chk("eret", eret_o, m_eret);
      chk("epc_we", exc_epc_we_o, m_epcwe);
      chk("bv_we", badvaddr_we_o, m_bvwe);
      chk("int_pending", int_pending_o, m_pend);
      if (m_busy > 0) chk("redirect", redirect_pc_o, m_redirect);
      if (m_we) begin
        chk("code", exc_code_o, m_code);
        chk("epc", exc_epc_o, m_epc);
        chk("bd", exc_bd_o, m_bd);
        if (m_bvwe) chk("badvaddr", exc_badvaddr_o, m_bv);
      end
    end
  end

  task automatic bubble();
    mem_valid_i = 0; mem_exc_i = '0; mem_sys_i = 0; mem_in_ds_i = 0;
  endtask

  task automatic issue(input logic [6:0] exc, input logic sys, input logic [31:0] pc,
                       input logic ds, input logic [31:0] bad);
    mem_valid_i = 1; mem_exc_i = exc; mem_sys_i = sys; mem_pc_i = pc;
    mem_in_ds_i = ds; mem_bad_vaddr_i = bad;
    @(negedge clk);
    bubble();
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flush", flush_o, 0);
    chk("rst_redirect", redirect_pc_o, 32'hBFC00380);
    chk("rst_we", exc_we_o, 0);
    chk("rst_code", exc_code_o, 0);
    chk("rst_pend", int_pending_o, 0);
    rst = 0;
    @(negedge clk);

    // ov, not in delay slot
    issue(7'b0001000, 0, 32'h80001000, 0, 32'h0);
    chk("ov_we", exc_we_o, 1);
    chk("ov_code", exc_code_o, 12);
    chk("ov_epc", exc_epc_o, 32'h80001000);
    chk("ov_epc_we", exc_epc_we_o, 1);
    chk("ov_redirect", redirect_pc_o, 32'hBFC00380);
    chk("ov_flush0", flush_o, 1);
    @(negedge clk);
    chk("ov_flush1", flush_o, 1);
    chk("ov_we_drop", exc_we_o, 0);
    @(negedge clk);
    chk("ov_flush2", flush_o, 0);
    drain();

    // syscall in delay slot
    issue(7'b0, 1, 32'h80002004, 1, 32'h0);
    chk("sys_epc", exc_epc_o, 32'h80002000);
    chk("sys_bd", exc_bd_o, 1);
    chk("sys_code", exc_code_o, 8);
    drain();

    // hardware interrupt 0 through the synchroniser
    cp0_status_i = 32'h00000401;
    hw_int_i = 6'b000001;
    @(negedge clk);
    chk("int_pend_1cyc", int_pending_o, 0);
    @(negedge clk);
    chk("int_pend_2cyc", int_pending_o, 1);
    issue(7'b0, 0, 32'h80003000, 0, 32'h0);
    chk("int_code", exc_code_o, 0);
    chk("int_epc", exc_epc_o, 32'h80003000);
    chk("int_we", exc_we_o, 1);
    cp0_status_i = 32'h0;
    drain();

    // ri together with a pending interrupt: interrupt wins
    cp0_status_i = 32'h00000401;
    issue(7'b0000100, 0, 32'h80005000, 0, 32'h0);
    chk("ri_int_code", exc_code_o, 0);
    chk("ri_int_bvwe", badvaddr_we_o, 0);
    cp0_status_i = 32'h0;
    hw_int_i = 6'b0;
    drain();

    // ades with EXL already set
    cp0_status_i = 32'h00000403;
    issue(7'b0100000, 0, 32'h80006000, 0, 32'h00000003);
    chk("ades_code", exc_code_o, 5);
    chk("ades_bv", exc_badvaddr_o, 32'h00000003);
    chk("ades_bvwe", badvaddr_we_o, 1);
    chk("ades_epcwe", exc_epc_we_o, 0);
    chk("ades_we", exc_we_o, 1);
    cp0_status_i = 32'h0;
    drain();

    // brk in delay slot at pc 0: EPC wraps
    issue(7'b0000001, 0, 32'h00000000, 1, 32'h0);
    chk("brk_code", exc_code_o, 9);
    chk("brk_epc_wrap", exc_epc_o, 32'hFFFFFFFC);
    drain();

    // eret, then reset while the flush is still active
    cp_epc_i = 32'h80004000;
    issue(7'b1000000, 0, 32'h80007000, 0, 32'h0);
    chk("eret_strobe", eret_o, 1);
    chk("eret_redirect", redirect_pc_o, 32'h80004000);
    chk("eret_we", exc_we_o, 0);
    chk("eret_flush", flush_o, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_flush", flush_o, 0);
    chk("rst_mid_eret", eret_o, 0);
    rst = 0;
    drain();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      mem_valid_i = ($urandom % 4) != 0;
      r = $urandom % 8;
      mem_exc_i = (r == 0) ? 7'($urandom) : (r < 3) ? 7'(1 << ($urandom % 7)) : 7'd0;
      mem_sys_i = ($urandom % 8) == 0;
      mem_pc_i = $urandom;
      mem_in_ds_i = 1'($urandom);
      mem_bad_vaddr_i = $urandom;
      if (($urandom % 16) == 0) hw_int_i = 6'($urandom);
      cp0_status_i = $urandom;
      cp0_cause_i = $urandom;
      cp_epc_i = $urandom;
      rst = ($urandom % 400) == 0;
      @(negedge clk);
    end
    rst = 0;
    bubble();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
